// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C format-FIFO arbiter.
// Entry layout matches the host format FIFO: {nakok, rcont, read, stop, start, fbyte}.
package i2c_arb_pkg;

   localparam int FmtEntryW = 13;

   typedef struct packed {
      logic       nakok;
      logic       rcont;
      logic       read;
      logic       stop;
      logic       start;
      logic [7:0] fbyte;
   } fmt_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OK      = 2'd0,
      NAK     = 2'd1,
      TIMEOUT = 2'd2,
      PROTO   = 2'd3
   } done_status_e;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Rotate-priority picker: first valid index at or above ptr_i, with wrap.
module i2c_arb_rr_pick #(
   parameter int NumReq = 4,
   parameter int IdW    = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] valid_i,
   input  logic [IdW-1:0]    ptr_i,
   output logic              found_o,
   output logic [IdW-1:0]    idx_o
);

   logic [IdW-1:0] cand;

   // Walk from the farthest slot down so the nearest valid one wins last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = IdW'((int'(ptr_i) + k) % NumReq);
         if (valid_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/i2c_fmt_arbiter.sv
// Shares the I2C host format-FIFO write port among NumReq requesters,
// granting whole start..stop transactions round-robin with NAK/timeout recovery.
module i2c_fmt_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NumReq        = 4,
   parameter int IdW           = $clog2(NumReq),
   parameter int TimeoutCycles = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumReq-1:0]           req_valid_i,
   input  logic [NumReq*FmtEntryW-1:0] req_data_i,
   output logic [NumReq-1:0]           req_ready_o,
   output logic                        fmt_valid_o,
   output logic [FmtEntryW-1:0]        fmt_data_o,
   input  logic                        fmt_ready_i,
   input  logic                        host_enable_i,
   input  logic                        host_nak_i,
   output logic                        owner_valid_o,
   output logic [IdW-1:0]              owner_id_o,
   output logic                        done_valid_o,
   output logic [IdW-1:0]              done_id_o,
   output logic [1:0]                  done_status_o
);

   localparam int TmrW = $clog2(TimeoutCycles + 1);
   localparam logic [TmrW-1:0] TmrMax  = TmrW'(TimeoutCycles);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

   arb_state_e     state_q;
   logic [IdW-1:0] owner_q;
   logic [IdW-1:0] rr_q;
   logic [TmrW-1:0] timer_q;
   logic [TmrW-1:0] timer_d;
   logic           done_valid_q;
   logic [IdW-1:0] done_id_q;
   done_status_e   done_status_q;

   logic           found;
   logic [IdW-1:0] pick_idx;
   logic [IdW-1:0] sel_idx;
   fmt_entry_t     sel_ent;
   logic           sel_valid;
   logic           own_hs;
   logic           starve;
   logic           expire;

   function automatic logic [IdW-1:0] next_id(logic [IdW-1:0] id);
      return (id == IdW'(NumReq - 1)) ? '0 : id + 1'b1;
   endfunction

   i2c_arb_rr_pick #(
      .NumReq (NumReq),
      .IdW    (IdW)
   ) u_pick (
      .valid_i (req_valid_i),
      .ptr_i   (rr_q),
      .found_o (found),
      .idx_o   (pick_idx)
   );

   // One entry mux serves both the IDLE head inspection and the owner path.
   assign sel_idx   = (state_q == IDLE) ? pick_idx : owner_q;
   assign sel_ent   = fmt_entry_t'(req_data_i[sel_idx*FmtEntryW +: FmtEntryW]);
   assign sel_valid = req_valid_i[sel_idx];

   assign own_hs = (state_q == OWN) && sel_valid && fmt_ready_i;
   assign starve = !sel_valid;
   assign expire = starve && (timer_q == TmrLast);

   always_comb begin
      timer_d = timer_q;
      if (own_hs) begin
         timer_d = '0;
      end else if (starve && timer_q != TmrMax) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_comb begin
      req_ready_o = '0;
      fmt_valid_o = 1'b0;
      fmt_data_o  = '0;
      if (!rst_i) begin
         unique case (state_q)
            IDLE: begin
               if (host_enable_i && found && !sel_ent.start) begin
                  req_ready_o[pick_idx] = 1'b1;
               end
            end
            OWN: begin
               fmt_valid_o          = sel_valid;
               fmt_data_o           = sel_ent;
               req_ready_o[owner_q] = fmt_ready_i;
            end
            FLUSH: begin
               req_ready_o[owner_q] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rr_q          <= '0;
         timer_q       <= '0;
         done_valid_q  <= 1'b0;
         done_id_q     <= '0;
         done_status_q <= OK;
      end else begin
         done_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (host_enable_i && found) begin
                  if (sel_ent.start) begin
                     owner_q <= pick_idx;
                     timer_q <= '0;
                     state_q <= OWN;
                  end else begin
                     done_valid_q  <= 1'b1;
                     done_id_q     <= pick_idx;
                     done_status_q <= PROTO;
                     rr_q          <= next_id(pick_idx);
                  end
               end
            end
            OWN: begin
               timer_q <= timer_d;
               // A NAK racing the stop handshake still reports NAK.
               if (own_hs && sel_ent.stop) begin
                  done_valid_q  <= 1'b1;
                  done_id_q     <= owner_q;
                  done_status_q <= host_nak_i ? NAK : OK;
                  rr_q          <= next_id(owner_q);
                  state_q       <= IDLE;
               end else if (host_nak_i) begin
                  done_valid_q  <= 1'b1;
                  done_id_q     <= owner_q;
                  done_status_q <= NAK;
                  state_q       <= FLUSH;
               end else if (expire) begin
                  done_valid_q  <= 1'b1;
                  done_id_q     <= owner_q;
                  done_status_q <= TIMEOUT;
                  rr_q          <= next_id(owner_q);
                  state_q       <= IDLE;
               end
            end
            FLUSH: begin
               if (sel_valid && sel_ent.stop) begin
                  rr_q    <= next_id(owner_q);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign owner_valid_o = (state_q != IDLE);
   assign owner_id_o    = (state_q != IDLE) ? owner_q : '0;
   assign done_valid_o  = done_valid_q;
   assign done_id_o     = done_id_q;
   assign done_status_o = done_status_q;

endmodule

// File: tb/tb_i2c_fmt_arbiter.sv
// Bench for i2c_fmt_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_i2c_fmt_arbiter;

   localparam int NR = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req_valid = '0;
   logic [NR*13-1:0] req_data = '0;
   logic [NR-1:0] req_ready;
   logic          fmt_valid;
   logic [12:0]   fmt_data;
   logic          fmt_ready = 1'b0;
   logic          host_en = 1'b0;
   logic          host_nak = 1'b0;
   logic          owner_valid;
   logic [1:0]    owner_id;
   logic          done_valid;
   logic [1:0]    done_id;
   logic [1:0]    done_status;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [12:0] q [NR][$];
   logic [NR-1:0] pop = '0;

   logic [12:0] fmt_log[$];
   int          fmt_cyc[$];
   int          dn_id[$];
   int          dn_st[$];
   int          dn_cyc[$];

   // Model state: who owns the port, whether it is being flushed, and the
   // round-robin start point; done expectations are one cycle delayed.
   int m_owner = -1;
   bit m_flush = 1'b0;
   int m_ptr = 0;
   int m_starve = 0;
   bit m_dv = 1'b0;
   int m_did = 0;
   int m_dst = 0;

   i2c_fmt_arbiter #(
      .NumReq        (NR),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .fmt_valid_o   (fmt_valid),
      .fmt_data_o    (fmt_data),
      .fmt_ready_i   (fmt_ready),
      .host_enable_i (host_en),
      .host_nak_i    (host_nak),
      .owner_valid_o (owner_valid),
      .owner_id_o    (owner_id),
      .done_valid_o  (done_valid),
      .done_id_o     (done_id),
      .done_status_o (done_status)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit vbit(int i);
      return ((req_valid >> i) & 4'd1) != 4'd0;
   endfunction

   function automatic logic [12:0] ent(int i);
      return 13'(req_data >> (i * 13));
   endfunction

   // Requester queues: pop what was accepted, then present the new head.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NR; i++) begin
         if (pop[i] && q[i].size() > 0) void'(q[i].pop_front());
      end
      pop = '0;
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = q[i].size() > 0;
         req_data[i*13 +: 13] = (q[i].size() > 0) ? q[i][0] : 13'h0;
      end
   end

   always @(negedge clk) begin
      logic [NR-1:0] e_rdy;
      logic          e_fv;
      logic [12:0]   e_fd;
      bit            e_ov;
      int            e_oid;
      bit            nv;
      int            nid;
      int            nst;
      int            pk;
      int            ow;
      bit            hs;
      cyc++;
      e_rdy = '0;
      e_fv  = 1'b0;
      e_fd  = '0;
      nv    = 1'b0;
      nid   = 0;
      nst   = 0;
      e_ov  = m_owner >= 0;
      e_oid = e_ov ? m_owner : 0;
      if (rst) begin
         m_owner = -1;
         m_flush = 1'b0;
         m_ptr = 0;
         m_starve = 0;
      end else if (m_owner < 0) begin
         if (host_en) begin
            pk = -1;
            for (int k = 0; k < NR; k++) begin
               if (pk < 0 && vbit((m_ptr + k) % NR)) pk = (m_ptr + k) % NR;
            end
            if (pk >= 0) begin
               if (ent(pk)[8]) begin
                  m_owner = pk;
                  m_starve = 0;
                  m_flush = 1'b0;
               end else begin
                  e_rdy = 4'(1 << pk);
                  nv = 1'b1;
                  nid = pk;
                  nst = 3;
                  m_ptr = (pk + 1) % NR;
               end
            end
         end
      end else if (!m_flush) begin
         ow = m_owner;
         e_fv = vbit(ow);
         e_fd = ent(ow);
         e_rdy = fmt_ready ? 4'(1 << ow) : '0;
         hs = vbit(ow) && fmt_ready;
         if (hs && e_fd[9]) begin
            nv = 1'b1;
            nid = ow;
            nst = host_nak ? 1 : 0;
            m_ptr = (ow + 1) % NR;
            m_owner = -1;
         end else if (host_nak) begin
            nv = 1'b1;
            nid = ow;
            nst = 1;
            m_flush = 1'b1;
         end else if (!vbit(ow) && m_starve + 1 >= TO) begin
            nv = 1'b1;
            nid = ow;
            nst = 2;
            m_ptr = (ow + 1) % NR;
            m_owner = -1;
         end
         if (hs) m_starve = 0;
         else if (!vbit(ow)) m_starve++;
      end else begin
         ow = m_owner;
         e_rdy = 4'(1 << ow);
         if (vbit(ow) && ent(ow)[9]) begin
            m_ptr = (ow + 1) % NR;
            m_owner = -1;
            m_flush = 1'b0;
         end
      end

      chk("req_ready", req_ready, e_rdy);
      chk("fmt_valid", fmt_valid, e_fv);
      if (e_fv) chk("fmt_data", fmt_data, e_fd);
      chk("owner_valid", owner_valid, e_ov);
      if (e_ov) chk("owner_id", owner_id, e_oid);
      chk("done_valid", done_valid, m_dv);
      if (m_dv) begin
         chk("done_id", done_id, m_did);
         chk("done_status", done_status, m_dst);
      end
      m_dv = nv;
      m_did = nid;
      m_dst = nst;

      pop = req_valid & req_ready;
      if (fmt_valid && fmt_ready) begin
         fmt_log.push_back(fmt_data);
         fmt_cyc.push_back(cyc);
      end
      if (done_valid) begin
         dn_id.push_back(int'(done_id));
         dn_st.push_back(int'(done_status));
         dn_cyc.push_back(cyc);
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic bit qs_empty();
      for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_logs();
      fmt_log.delete();
      fmt_cyc.delete();
      dn_id.delete();
      dn_st.delete();
      dn_cyc.delete();
   endtask

   task automatic wait_quiet(string nm, int budget);
      int c;
      c = 0;
      while (c < budget) begin
         step(1);
         if (!owner_valid && qs_empty()) break;
         c++;
      end
      chk({nm, "_bounded"}, c < budget, 1);
      step(3);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int c;
      step(3);
      chk("rst_owner_valid", owner_valid, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_fmt_valid", fmt_valid, 0);
      rst = 1'b0;
      host_en = 1'b1;
      fmt_ready = 1'b1;

      // Single requester, back-to-back entries.
      clear_logs();
      q[0].push_back(13'h1A0);
      q[0].push_back(13'h011);
      q[0].push_back(13'h222);
      wait_quiet("t1", 50);
      chk("t1_fmt_count", fmt_log.size(), 3);
      if (fmt_log.size() == 3) begin
         chk("t1_fmt0", fmt_log[0], 13'h1A0);
         chk("t1_fmt2", fmt_log[2], 13'h222);
         chk("t1_gap", fmt_cyc[2] - fmt_cyc[0], 2);
      end
      chk("t1_done_count", dn_id.size(), 1);
      if (dn_id.size() == 1) begin
         chk("t1_done_id", dn_id[0], 0);
         chk("t1_done_st", dn_st[0], 0);
      end

      // Two contenders, Req1 then Req3.
      clear_logs();
      q[1].push_back(13'h131);
      q[1].push_back(13'h232);
      q[3].push_back(13'h171);
      q[3].push_back(13'h272);
      wait_quiet("t2", 50);
      chk("t2_done_count", dn_id.size(), 2);
      if (dn_id.size() == 2) begin
         chk("t2_done_id0", dn_id[0], 1);
         chk("t2_done_id1", dn_id[1], 3);
      end
      if (fmt_log.size() == 4) chk("t2_fmt2", fmt_log[2], 13'h171);
      else chk("t2_fmt_count", fmt_log.size(), 4);

      // NAK after the second entry of Req2.
      clear_logs();
      q[2].push_back(13'h150);
      q[2].push_back(13'h001);
      q[2].push_back(13'h002);
      q[2].push_back(13'h003);
      q[2].push_back(13'h204);
      c = 0;
      while (fmt_log.size() < 2 && c < 30) begin
         step(1);
         c++;
      end
      chk("t3_second_entry_bounded", c < 30, 1);
      fmt_ready = 1'b0;
      host_nak = 1'b1;
      step(1);
      host_nak = 1'b0;
      fmt_ready = 1'b1;
      wait_quiet("t3", 50);
      chk("t3_fmt_count", fmt_log.size(), 2);
      chk("t3_done_count", dn_id.size(), 1);
      if (dn_id.size() == 1) begin
         chk("t3_done_id", dn_id[0], 2);
         chk("t3_done_st", dn_st[0], 1);
         if (fmt_cyc.size() == 2) chk("t3_done_lat", dn_cyc[0] - fmt_cyc[1], 2);
      end

      // Owner starves: timeout, then a stray non-start entry.
      clear_logs();
      q[0].push_back(13'h1A5);
      wait_quiet("t4a", 60);
      q[0].push_back(13'h200);
      wait_quiet("t4a_proto", 20);
      chk("t4a_done_count", dn_id.size(), 2);
      if (dn_id.size() == 2 && fmt_cyc.size() == 1) begin
         chk("t4a_done_st0", dn_st[0], 2);
         chk("t4a_done_id0", dn_id[0], 0);
         chk("t4a_timeout_lat", dn_cyc[0] - fmt_cyc[0], 9);
         chk("t4a_done_st1", dn_st[1], 3);
      end

      // Host backpressure alone never times out.
      clear_logs();
      fmt_ready = 1'b0;
      q[0].push_back(13'h110);
      q[0].push_back(13'h211);
      step(20);
      chk("t4b_still_owner", owner_valid, 1);
      fmt_ready = 1'b1;
      wait_quiet("t4b", 30);
      chk("t4b_done_count", dn_id.size(), 1);
      if (dn_id.size() == 1) chk("t4b_done_st", dn_st[0], 0);
      chk("t4b_fmt_count", fmt_log.size(), 2);

      // Head without start is dropped.
      clear_logs();
      q[1].push_back(13'h033);
      wait_quiet("t5", 20);
      chk("t5_fmt_count", fmt_log.size(), 0);
      chk("t5_done_count", dn_id.size(), 1);
      if (dn_id.size() == 1) begin
         chk("t5_done_id", dn_id[0], 1);
         chk("t5_done_st", dn_st[0], 3);
      end

      // Reset mid-transaction, then grants disabled.
      clear_logs();
      fmt_ready = 1'b0;
      q[0].push_back(13'h101);
      q[0].push_back(13'h002);
      step(4);
      chk("t6_owned", owner_valid, 1);
      rst = 1'b1;
      for (int i = 0; i < NR; i++) q[i].delete();
      step(1);
      chk("t6_rst_owner_valid", owner_valid, 0);
      chk("t6_rst_fmt_valid", fmt_valid, 0);
      chk("t6_rst_req_ready", req_ready, 0);
      chk("t6_rst_done_valid", done_valid, 0);
      rst = 1'b0;
      host_en = 1'b0;
      fmt_ready = 1'b1;
      q[0].push_back(13'h1A1);
      q[2].push_back(13'h1A2);
      step(10);
      chk("t6_no_grant", owner_valid, 0);
      chk("t6_no_done", dn_id.size(), 0);
      chk("t6_no_fmt", fmt_log.size(), 0);
      chk("t6_not_consumed", q[0].size(), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_fmt_arbiter.md
Name: i2c_fmt_arbiter

Overview:
- Shares the single I2C host format-FIFO write port among NumReq independent requesters, such as firmware shims, DMA or sensor pollers.
- Grants the port for a whole transaction, from a start-flagged entry through the stop-flagged entry.
- Arbitrates round-robin, enforces transaction framing, and recovers from host NAKs and stalled owners.
- Sits between the requesters and the i2c format-FIFO write interface; reports per-transaction completion status.

Parameters:
- NumReq, 4, number of requesters (2..8).
- IdW, $clog2(NumReq), requester index width (derived).
- TimeoutCycles, 1024, consecutive owner-starvation cycles before forced release (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NumReq  requester entry valid
- req_data_i  in  NumReq*13  per requester: {nakok, rcont, read, stop, start, fbyte[7:0]}
- req_ready_o  out  NumReq  entry accepted (consumed or dropped)
- fmt_valid_o  out  1  entry to format FIFO valid
- fmt_data_o  out  13  entry to format FIFO
- fmt_ready_i  in  1  format FIFO can accept
- host_enable_i  in  1  host mode enabled; no new grants while low
- host_nak_i  in  1  single-cycle NAK event from the host
- owner_valid_o  out  1  a requester currently owns the port
- owner_id_o  out  IdW  current owner index
- done_valid_o  out  1  single-cycle completion pulse
- done_id_o  out  IdW  requester the completion refers to
- done_status_o  out  2  0=OK, 1=NAK, 2=TIMEOUT, 3=PROTO

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE, rr_ptr=0, timer=0.
  - Every output is 0.
  - Reset mid-transaction aborts silently: no done pulse, no stop is injected.
- State IDLE:
  - If host_enable_i=1, scan from rr_ptr upward with wrap and pick the first i with req_valid_i[i].
  - If the picked head has start=1: register owner=i, go to OWN next cycle. The entry is not consumed this cycle and req_ready_o stays 0.
  - If the picked head has start=0: assert req_ready_o[i] for one cycle (entry dropped), pulse done with status PROTO and id i, set rr_ptr=i+1 mod NumReq, stay IDLE.
  - One pick per cycle. If host_enable_i=0, all req_ready_o=0.
- State OWN:
  - Combinational pass-through: fmt_valid_o=req_valid_i[owner], fmt_data_o=req_data_i[owner], req_ready_o[owner]=fmt_ready_i.
  - All other req_ready_o are 0.
  - A start=1 entry from the owner mid-transaction is forwarded unchanged (repeated start).
  - Handshake of an entry with stop=1: pulse done OK, rr_ptr=owner+1, go IDLE.
  - host_nak_i=1: pulse done NAK and go FLUSH. If a stop handshake occurs in the same cycle, report NAK and go IDLE instead of FLUSH.
- Timer (OWN only):
  - Resets to 0 on each fmt handshake and on entry to OWN.
  - Increments while req_valid_i[owner]=0; holds while fmt_valid_o=1 and fmt_ready_i=0, since host backpressure is not starvation.
  - Saturating, width $clog2(TimeoutCycles+1).
  - At timer==TimeoutCycles: pulse done TIMEOUT, rr_ptr=owner+1, go IDLE. Later non-start entries from that requester are dropped as PROTO.
- State FLUSH:
  - fmt_valid_o=0; req_ready_o[owner]=1; the owner's entries are discarded.
  - The discarded entry with stop=1 moves the state to IDLE with rr_ptr=owner+1. No further done pulse.
- owner_valid_o=1 in OWN and FLUSH; owner_id_o holds the owner there and is 0 in IDLE.
- Done outputs are registered: one pulse per event, one cycle after the triggering edge.
- Grant latency: the first entry can handshake in the cycle after it is picked.

Decomposition:
- Shared package i2c_arb_pkg:
  - fmt_entry_t packed struct (fbyte, start, stop, read, rcont, nakok), width constant FmtEntryW=13.
  - arb_state_e: IDLE, OWN, FLUSH.
  - done_status_e: OK, NAK, TIMEOUT, PROTO.
- Sub-module i2c_arb_rr_pick: combinational rotate-priority picker. Inputs: valid vector, rr_ptr. Outputs: found flag, index.
- FSM, timer and done registers stay in i2c_fmt_arbiter.

Test Plan:
1. Req0 sends {start,0xA0},{0x11},{stop,0x22} with fmt_ready_i=1 -> three entries out on consecutive cycles starting 1 cycle after pick; done OK id0; rr_ptr=1.
2. Req1 and Req3 both valid with start entries, rr_ptr=0 -> Req1 granted first; Req3 ready stays 0 until Req1's stop; then Req3 granted; done ids 1 then 3.
3. Req2 owner, host_nak_i pulses after the 2nd entry -> done NAK id2 next cycle; Req2's remaining 3 entries consumed with fmt_valid_o=0; IDLE after its stop entry.
4. TimeoutCycles=8, Req0 owner deasserts valid for 8 cycles while fmt_ready_i=0 for a further 20 -> done TIMEOUT id0 exactly at count 8; the backpressure cycles do not advance the timer (separate sub-case).
5. Idle with Req1 head lacking start -> req_ready_o[1] pulses 1 cycle, done PROTO id1, no fmt_valid_o.
6. rst_i asserted mid-OWN with fmt_ready_i=0 -> next cycle all outputs 0, no done pulse; host_enable_i=0 afterwards -> no grant despite valid start requests.
